// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back data cache controller with a line-wide req/ack memory port.
// Hits are served combinationally in IDLE; misses stall the pipe through WRITEBACK/REFILL.
module dcache_ctrl #(
  parameter int INDEX_W   = 2,
  parameter int LINE_BITS = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MEM_R_EN,
  input  logic                 MEM_W_EN,
  input  logic                 is_byte,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  output logic                 block_pipe_data_cache,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [LINE_BITS-1:0] mem_wline,
  input  logic [LINE_BITS-1:0] mem_rline,
  input  logic                 mem_ack
);
  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 28 - INDEX_W;
  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;
  state_t               r_state;
  logic [LINES-1:0]     r_valid, r_dirty;
  logic [TAG_W-1:0]     r_tag  [LINES];
  logic [LINE_BITS-1:0] r_data [LINES];
  logic [TAG_W-1:0]     w_tag;
  logic [INDEX_W-1:0]   w_idx;
  logic [3:0]           w_off;
  logic                 w_req, w_hit, w_store_hit;
  logic [LINE_BITS-1:0] w_line, w_merged;
  logic [31:0]          w_word;
  logic [7:0]           w_byte;
  assign w_tag       = addr[31:4+INDEX_W];
  assign w_idx       = addr[3+INDEX_W:4];
  assign w_off       = addr[3:0];
  assign w_req       = MEM_R_EN | MEM_W_EN;
  assign w_hit       = r_valid[w_idx] && r_tag[w_idx] == w_tag;
  assign w_store_hit = r_state == IDLE && MEM_W_EN && w_hit;
  assign w_line      = r_data[w_idx];
  assign w_word      = w_line[{w_off[3:2], 5'b0} +: 32];
  assign w_byte      = w_line[{w_off, 3'b0} +: 8];
  always_comb begin
    w_merged = w_line;
    if (is_byte) w_merged[{w_off, 3'b0} +: 8] = wdata[7:0];
    else         w_merged[{w_off[3:2], 5'b0} +: 32] = wdata;
  end
  // reset gates the combinational outputs so nothing leaks while it is held
  assign block_pipe_data_cache = reset && (r_state != IDLE || (w_req && !w_hit));
  assign rdata     = (reset && r_state == IDLE && MEM_R_EN && !MEM_W_EN && w_hit) ?
                     (is_byte ? {24'b0, w_byte} : w_word) : '0;
  assign mem_req   = r_state != IDLE;
  assign mem_we    = r_state == WRITEBACK;
  assign mem_addr  = r_state == WRITEBACK ? {r_tag[w_idx], w_idx, 4'b0} :
                     r_state == REFILL    ? {w_tag, w_idx, 4'b0} : '0;
  assign mem_wline = r_state == WRITEBACK ? w_line : '0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      case (r_state)
        IDLE:
          if (w_req && !w_hit)
            r_state <= (r_valid[w_idx] && r_dirty[w_idx]) ? WRITEBACK : REFILL;
          else if (w_store_hit)
            r_dirty[w_idx] <= 1'b1;
        WRITEBACK:
          if (mem_ack) begin
            r_dirty[w_idx] <= 1'b0;
            r_state        <= REFILL;
          end
        REFILL:
          if (mem_ack) begin
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
            r_state        <= IDLE;
          end
        default: r_state <= IDLE;
      endcase
    end
  end
  // line storage needs no reset: valid bits alone qualify its contents
  always_ff @(posedge clk) begin
    if (r_state == REFILL && mem_ack) begin
      r_data[w_idx] <= mem_rline;
      r_tag[w_idx]  <= w_tag;
    end else if (w_store_hit) begin
      r_data[w_idx] <= w_merged;
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: random loads/stores against a flat architectural memory model; the bench plays main memory.
module tb_dcache_ctrl;
  logic         clk = 0, reset = 0;
  logic         MEM_R_EN = 0, MEM_W_EN = 0, is_byte = 0, mem_ack = 0;
  logic [31:0]  addr = 0, wdata = 0, rdata, mem_addr;
  logic         block_pipe_data_cache, mem_req, mem_we;
  logic [127:0] mem_wline, mem_rline = 0;
  int           nvec = 0, nerr = 0;
  logic [127:0] arch [logic [27:0]];
  logic [127:0] mm   [logic [27:0]];
  logic         mv [4], md [4];
  logic [25:0]  mt [4];

  dcache_ctrl dut (
    .clk(clk), .reset(reset), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .is_byte(is_byte),
    .addr(addr), .wdata(wdata), .rdata(rdata), .block_pipe_data_cache(block_pipe_data_cache),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wline(mem_wline),
    .mem_rline(mem_rline), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic ensure(input logic [27:0] la);
    if (!arch.exists(la)) begin
      arch[la] = {$urandom, $urandom, $urandom, $urandom};
      mm[la]   = arch[la];
    end
  endtask

  function automatic logic [31:0] exp_load(input logic [31:0] a, input bit b);
    logic [127:0] l = arch[a[31:4]];
    return b ? {24'b0, l[a[3:0]*8 +: 8]} : l[a[3:2]*32 +: 32];
  endfunction

  task automatic model_reset();
    foreach (mv[i]) begin mv[i] = 0; md[i] = 0; end
    foreach (mm[k]) arch[k] = mm[k];
  endtask

  // called one step after a rising edge with the DUT expected in a memory state
  task automatic handshake(input bit we, input logic [27:0] la);
    int lat = $urandom_range(0, 3);
    repeat (lat) @(posedge clk);
    #1;
    chk("req", mem_req, 1);
    chk("we", mem_we, we);
    chk("maddr", mem_addr, {la, 4'b0});
    chk("blk_busy", block_pipe_data_cache, 1);
    if (we) begin
      chk("wline", mem_wline, arch[la]);
      mm[la] = mem_wline;
    end else mem_rline = mm[la];
    mem_ack = 1;
    @(posedge clk); #1;
    mem_ack = 0;
    mem_rline = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic do_op(input bit r, input bit w, input bit b, input logic [31:0] a, input logic [31:0] d);
    logic [27:0] la = a[31:4];
    logic [1:0]  idx = a[5:4];
    logic [25:0] tg = a[31:6];
    bit hit;
    logic [127:0] l;
    ensure(la);
    MEM_R_EN = r; MEM_W_EN = w; is_byte = b; addr = a; wdata = d;
    #1;
    hit = mv[idx] && mt[idx] == tg;
    chk("blk_now", block_pipe_data_cache, !hit);
    if (!hit) begin
      @(posedge clk); #1;
      if (mv[idx] && md[idx]) begin
        handshake(1, {mt[idx], idx});
        md[idx] = 0;
      end
      handshake(0, la);
      mv[idx] = 1; mt[idx] = tg; md[idx] = 0;
      chk("blk_after", block_pipe_data_cache, 0);
    end
    chk("rdata", rdata, (r && !w) ? exp_load(a, b) : 32'h0);
    @(posedge clk); #1;
    if (w) begin
      l = arch[la];
      if (b) l[a[3:0]*8 +: 8] = d[7:0];
      else   l[a[3:2]*32 +: 32] = d;
      arch[la] = l;
      md[idx] = 1;
    end
    MEM_R_EN = 0; MEM_W_EN = 0;
  endtask

  initial begin
    model_reset();
    arch[28'h10] = {32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
    mm[28'h10]   = arch[28'h10];
    MEM_R_EN = 1; addr = 32'h104;
    #1;
    chk("rst_blk", block_pipe_data_cache, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_wline", mem_wline, 0);
    MEM_R_EN = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    do_op(1, 0, 0, 32'h104, 0);
    do_op(0, 1, 0, 32'h104, 32'h12345678);
    do_op(1, 0, 0, 32'h104, 0);
    do_op(1, 0, 0, 32'h204, 0);
    do_op(0, 1, 0, 32'h104, 32'h11223344);
    do_op(0, 1, 1, 32'h105, 32'h000000AB);
    do_op(1, 0, 0, 32'h104, 0);
    do_op(1, 0, 1, 32'h106, 0);
    // reset while the refill for 0x304 is outstanding
    ensure(28'h30);
    MEM_R_EN = 1; is_byte = 0; addr = 32'h304;
    #1;
    chk("mid_blk", block_pipe_data_cache, 1);
    @(posedge clk); #1;
    if (mv[0] && md[0]) begin
      handshake(1, {mt[0], 2'b0});
      md[0] = 0;
    end
    chk("mid_req", mem_req, 1);
    chk("mid_we", mem_we, 0);
    reset = 0;
    #1;
    chk("mid_req_drop", mem_req, 0);
    chk("mid_blk_drop", block_pipe_data_cache, 0);
    chk("mid_maddr", mem_addr, 0);
    mem_ack = 1;
    @(posedge clk); #1;
    mem_ack = 0; MEM_R_EN = 0;
    @(posedge clk); #1;
    reset = 1;
    model_reset();
    do_op(1, 0, 0, 32'h104, 0);
    // stray ack with no request pending
    mem_ack = 1;
    @(posedge clk); #1;
    mem_ack = 0;
    chk("stray_blk", block_pipe_data_cache, 0);
    chk("stray_req", mem_req, 0);
    chk("stray_rdata", rdata, 0);
    do_op(1, 0, 0, 32'h104, 0);
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      bit w = $urandom_range(0, 1);
      bit b = $urandom_range(0, 1);
      a = {26'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
      if (!b) a[1:0] = 2'b0;
      do_op(!w, w, b, a, $urandom);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
